mesh_term_sink: RTL and testbench

- Hardware terminal endpoint attached to one external port of the mesh router (mesh_gnrtr).
- Drains packets from the router's output side (pndng/data_out/pop) and checks each packet's destination against this terminal's own row/column.
- Buffers accepted packets in a small FIFO for a local consumer, using a valid/ready handshake.
- Drops and counts misrouted packets; acts as the receiving end of traffic the stimulus side injects through popin/data_out_i_in/pndng_i_in.

---
 rtl/mesh_pkg.sv | 34 +++
 rtl/term_fifo.sv | 52 +++++
 rtl/mesh_term_sink.sv | 105 ++++++++++
 tb/tb_mesh_term_sink.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared definitions for mesh terminal endpoints: packet field layout,
// terminal FSM states and the destination-match helper.
package mesh_pkg;

    localparam int PKT_W        = 32;
    localparam int NXT_JUMP_MSB = 31;
    localparam int NXT_JUMP_LSB = 24;
    localparam int ROW_MSB      = 23;
    localparam int ROW_LSB      = 20;
    localparam int COL_MSB      = 19;
    localparam int COL_LSB      = 16;
    localparam int MODE_BIT     = 15;
    localparam int PYLD_W       = 15;

    typedef enum logic {
        IDLE,
        COMMIT
    } term_state_e;

    function automatic logic dest_match(
        input logic [PKT_W-1:0] pkt,
        input logic [3:0]       row,
        input logic [3:0]       col,
        input logic [7:0]       bdcst
    );
        logic hit_rc;
        logic hit_bc;
        hit_rc = (pkt[ROW_MSB:ROW_LSB] == row) &&
                 (pkt[COL_MSB:COL_LSB] == col);
        hit_bc = (pkt[NXT_JUMP_MSB:NXT_JUMP_LSB] == bdcst);
        return hit_rc || hit_bc;
    endfunction

endpackage

// File: rtl/term_fifo.sv
// Synchronous first-word-fall-through FIFO shared by mesh terminals.
// Push while full is honoured only when a pop happens in the same cycle.
module term_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mesh_term_sink.sv
// Receiving terminal on a mesh router port: drains router words, keeps
// packets addressed here (or broadcast) and counts the misrouted ones.
module mesh_term_sink
    import mesh_pkg::*;
#(
    parameter int         pckg_sz    = 32,
    parameter int         fifo_depth = 4,
    parameter logic [7:0] bdcst      = 8'hFF,
    parameter logic [3:0] MY_ROW     = 4'h0,
    parameter logic [3:0] MY_COL     = 4'h1,
    parameter int         CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pndng,
    input  logic [pckg_sz-1:0] data_out,
    output logic               pop,
    output logic               out_valid,
    output logic [pckg_sz-1:0] out_data,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   rx_cnt,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               fifo_full
);

    localparam int CW = $clog2(fifo_depth) + 1;

    term_state_e        state;
    term_state_e        state_d;
    logic [pckg_sz-1:0] cap_reg;
    logic [pckg_sz-1:0] cap_d;
    logic               pop_d;
    logic               push;
    logic               rx_inc;
    logic               drop_inc;
    logic               hit;
    logic               fifo_empty;
    logic [CW-1:0]      count;

    assign hit = dest_match(cap_reg[PKT_W-1:0], MY_ROW, MY_COL, bdcst);

    always_comb begin
        state_d  = state;
        cap_d    = cap_reg;
        pop_d    = 1'b0;
        push     = 1'b0;
        rx_inc   = 1'b0;
        drop_inc = 1'b0;
        unique case (state)
            IDLE: begin
                // Room is checked here; the only push is in COMMIT.
                if (pndng && (count < CW'(fifo_depth))) begin
                    cap_d   = data_out;
                    pop_d   = 1'b1;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                push     = hit;
                rx_inc   = hit;
                drop_inc = !hit;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cap_reg  <= '0;
            pop      <= 1'b0;
            rx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            state   <= state_d;
            cap_reg <= cap_d;
            pop     <= pop_d;
            if (rx_inc && (rx_cnt != '1)) begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
            if (drop_inc && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = !fifo_empty;

    term_fifo #(
        .WIDTH (pckg_sz),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (push),
        .wr_data (cap_reg),
        .pop     (out_valid && out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

endmodule

// File: tb/tb_mesh_term_sink.sv
// Directed bench for mesh_term_sink: a queue models the router output
// port, a list collects words handed to the local consumer.
module tb_mesh_term_sink;

    logic        clk;
    logic        reset;
    logic        pndng;
    logic [31:0] data_out;
    logic        pop;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [15:0] rx_cnt;
    logic [15:0] drop_cnt;
    logic        fifo_full;

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;
    int bad_pop  = 0;

    logic [31:0] q   [$];
    logic [31:0] rcv [$];
    logic [31:0] exp_w;

    mesh_term_sink dut (
        .clk       (clk),
        .reset     (reset),
        .pndng     (pndng),
        .data_out  (data_out),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .rx_cnt    (rx_cnt),
        .drop_cnt  (drop_cnt),
        .fifo_full (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task drive();
        pndng    = (q.size() != 0);
        data_out = (q.size() != 0) ? q[0] : 32'h0;
    endtask

    // Called at a falling edge: observe the cycle, then advance one clock.
    task tick();
        if (out_valid && out_ready) rcv.push_back(out_data);
        if (pop) begin
            pops++;
            if (fifo_full) bad_pop++;
            if (q.size() != 0) q.delete(0);
        end
        @(posedge clk);
        @(negedge clk);
        drive();
    endtask

    initial begin
        reset     = 1'b0;
        pndng     = 1'b0;
        data_out  = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_pop", {31'd0, pop}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_rx", {16'd0, rx_cnt}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        check("rst_full", {31'd0, fifo_full}, 32'd0);

        reset = 1'b1;
        tick();

        // Directed accept
        q.push_back(32'h0201_8AAA);
        drive();
        tick();
        check("acc_pop", {31'd0, pop}, 32'd1);
        check("acc_valid_early", {31'd0, out_valid}, 32'd0);
        tick();
        check("acc_pop_off", {31'd0, pop}, 32'd0);
        check("acc_valid", {31'd0, out_valid}, 32'd1);
        check("acc_data", out_data, 32'h0201_8AAA);
        check("acc_rx", {16'd0, rx_cnt}, 32'd1);
        check("acc_drop", {16'd0, drop_cnt}, 32'd0);
        check("acc_pops", pops, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("acc_drained", {31'd0, out_valid}, 32'd0);
        check("acc_rcv", rcv.size() == 1 ? rcv[0] : 32'hDEAD, 32'h0201_8AAA);

        // Misroute
        q.push_back(32'h0245_1234);
        drive();
        tick();
        tick();
        check("mis_valid", {31'd0, out_valid}, 32'd0);
        check("mis_drop", {16'd0, drop_cnt}, 32'd1);
        check("mis_rx", {16'd0, rx_cnt}, 32'd1);
        check("mis_pops", pops, 32'd2);

        // Broadcast
        q.push_back(32'hFF33_0001);
        drive();
        tick();
        tick();
        check("bc_valid", {31'd0, out_valid}, 32'd1);
        check("bc_data", out_data, 32'hFF33_0001);
        check("bc_rx", {16'd0, rx_cnt}, 32'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure: six matching packets against a four-entry buffer
        rcv.delete();
        pops = 0;
        for (int i = 0; i < 6; i++) q.push_back(32'h0001_0010 + i);
        drive();
        repeat (20) tick();
        check("bp_pops", pops, 32'd4);
        check("bp_full", {31'd0, fifo_full}, 32'd1);
        check("bp_pop_low", {31'd0, pop}, 32'd0);
        check("bp_left", q.size(), 32'd2);
        check("bp_hold", out_data, 32'h0001_0010);
        out_ready = 1'b1;
        repeat (30) tick();
        out_ready = 1'b0;
        check("bp_rcv_n", rcv.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            exp_w = 32'h0001_0010 + i;
            check("bp_order", i < rcv.size() ? rcv[i] : 32'hDEAD, exp_w);
        end
        check("bp_rx", {16'd0, rx_cnt}, 32'd8);
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Fill, then drain while a new match is committed
        rcv.delete();
        for (int i = 0; i < 4; i++) q.push_back(32'h0001_0100 + i);
        drive();
        repeat (12) tick();
        check("pp_full", {31'd0, fifo_full}, 32'd1);
        q.push_back(32'h0001_0104);
        drive();
        out_ready = 1'b1;
        repeat (20) tick();
        out_ready = 1'b0;
        check("pp_rcv_n", rcv.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            exp_w = 32'h0001_0100 + i;
            check("pp_order", i < rcv.size() ? rcv[i] : 32'hDEAD, exp_w);
        end
        check("pp_rx", {16'd0, rx_cnt}, 32'd13);
        check("pp_not_full", {31'd0, fifo_full}, 32'd0);

        // Asynchronous reset during COMMIT
        rcv.delete();
        q.push_back(32'h0201_8BBB);
        drive();
        tick();
        check("ar_pop_commit", {31'd0, pop}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("ar_pop", {31'd0, pop}, 32'd0);
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_rx", {16'd0, rx_cnt}, 32'd0);
        check("ar_drop", {16'd0, drop_cnt}, 32'd0);
        check("ar_full", {31'd0, fifo_full}, 32'd0);
        @(negedge clk);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("ar_recap_valid", {31'd0, out_valid}, 32'd1);
        check("ar_recap_data", out_data, 32'h0201_8BBB);
        check("ar_recap_rx", {16'd0, rx_cnt}, 32'd1);
        check("ar_recap_q", q.size(), 32'd0);

        check("pop_when_full", bad_pop, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
